// File: rtl/segment7_pkg.sv
// Shared types and constants for the 7-segment display reader.
// Patterns are active-low, bit6=a ... bit0=g.
// Codes: 0..9 for digits, CODE_BLANK for an all-off digit, CODE_INVALID otherwise.
package segment7_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_TRACK = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    localparam logic [6:0] PAT_0 = 7'b0000001;
    localparam logic [6:0] PAT_1 = 7'b1001111;
    localparam logic [6:0] PAT_2 = 7'b0010010;
    localparam logic [6:0] PAT_3 = 7'b0000110;
    localparam logic [6:0] PAT_4 = 7'b1001100;
    localparam logic [6:0] PAT_5 = 7'b0100100;
    localparam logic [6:0] PAT_6 = 7'b0100000;
    localparam logic [6:0] PAT_7 = 7'b0001111;
    localparam logic [6:0] PAT_8 = 7'b0000000;
    localparam logic [6:0] PAT_9 = 7'b0000100;
    localparam logic [6:0] PAT_BLANK = 7'b1111111;

    localparam logic [3:0] CODE_INVALID = 4'hF;
    localparam logic [3:0] CODE_BLANK   = 4'hA;

endpackage

// File: rtl/segment7_encode.sv
// Purpose: combinational segment pattern -> BCD code lookup.
// Latency: 0 cycles. Backpressure: none (pure combinational).
// Option: SEG7_READER_BLANK_EN maps the all-off pattern to CODE_BLANK.
module segment7_encode
    import segment7_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] code
);

    // Exact match against the ten digit patterns; anything else is invalid.
    always_comb begin
        code = CODE_INVALID;
        case (seg)
            PAT_0: code = 4'd0;
            PAT_1: code = 4'd1;
            PAT_2: code = 4'd2;
            PAT_3: code = 4'd3;
            PAT_4: code = 4'd4;
            PAT_5: code = 4'd5;
            PAT_6: code = 4'd6;
            PAT_7: code = 4'd7;
            PAT_8: code = 4'd8;
            PAT_9: code = 4'd9;
`ifdef SEG7_READER_BLANK_EN
            PAT_BLANK: code = CODE_BLANK;
`else
            PAT_BLANK: code = CODE_INVALID;
`endif
            default: code = CODE_INVALID;
        endcase
    end

endmodule

// File: rtl/segment7_reader.sv
// Purpose: debounce a multiplexed 7-seg bus into a BCD frame snapshot (option: SEG7_READER_BLANK_EN).
// Latency: 1 input-register cycle + STABLE_CNT samples per digit; snapshot one edge after the frame completes.
// Backpressure: out_valid holds until out_ready; a frame completing meanwhile is dropped and flags overrun.
module segment7_reader
    import segment7_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int STABLE_CNT = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [6:0]              seg,
    input  logic [NUM_DIGITS-1:0]   anode,
    input  logic                    out_ready,
    output logic                    out_valid,
    output logic [4*NUM_DIGITS-1:0] out_digits,
    output logic                    pattern_err,
    output logic                    overrun
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int ZC_W  = IDX_W + 1;
    localparam logic [3:0] CNT_LAST = 4'(STABLE_CNT - 1);
    localparam bit ONE_SHOT = (STABLE_CNT == 1);

    logic [6:0]                  seg_q;
    logic [NUM_DIGITS-1:0]       anode_q;
    logic [3:0]                  samp_code;
    logic [IDX_W-1:0]            samp_idx;
    logic [ZC_W-1:0]             zero_cnt;
    logic                        samp_vld;
    state_t                      state, state_nxt;
    logic [3:0]                  cnt;
    logic [IDX_W-1:0]            cand_idx;
    logic [3:0]                  cand_code;
    logic                        fresh, accept, code_ok, frame_done, hs;
    logic [NUM_DIGITS-1:0]       seen, seen_nxt;
    logic [NUM_DIGITS-1:0][3:0]  digit_reg;

    segment7_encode u_encode (
        .seg  (seg_q),
        .code (samp_code)
    );

    // Register the raw bus once; idle value is all segments/anodes off.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_q   <= '1;
            anode_q <= '1;
        end else begin
            seg_q   <= seg;
            anode_q <= anode;
        end
    end

    // A sample is usable only when exactly one anode is driven low.
    always_comb begin
        zero_cnt = '0;
        samp_idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!anode_q[i]) begin
                zero_cnt = zero_cnt + ZC_W'(1);
                samp_idx = IDX_W'(i);
            end
        end
    end

    assign samp_vld   = (zero_cnt == ZC_W'(1));
    // A new candidate starts from idle or whenever the (digit, code) pair changes.
    assign fresh      = (state == S_IDLE) || (samp_idx != cand_idx) || (samp_code != cand_code);
    assign code_ok    = (samp_code != CODE_INVALID);
    assign frame_done = &seen;
    assign hs         = out_valid && out_ready;

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // FSM next state: invalid samples always fall back to idle.
    always_comb begin
        state_nxt = state;
        if (!samp_vld)                state_nxt = S_IDLE;
        else if (fresh)               state_nxt = ONE_SHOT ? S_HOLD : S_TRACK;
        else if (state == S_TRACK)    state_nxt = (cnt == CNT_LAST) ? S_HOLD : S_TRACK;
        else                          state_nxt = S_HOLD;
    end

    // FSM outputs: accept on the sample that brings the run to STABLE_CNT.
    always_comb begin
        accept = 1'b0;
        if (samp_vld) begin
            if (fresh)                 accept = ONE_SHOT;
            else if (state == S_TRACK) accept = (cnt == CNT_LAST);
        end
    end

    // Run counter and the candidate it is counting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            cand_idx  <= '0;
            cand_code <= '0;
        end else if (!samp_vld) begin
            cnt <= '0;
        end else if (fresh) begin
            cnt       <= 4'd1;
            cand_idx  <= samp_idx;
            cand_code <= samp_code;
        end else if (state == S_TRACK) begin
            cnt <= cnt + 4'd1;
        end
    end

    // Seen mask: drop the finished frame first, then mark any digit accepted this cycle.
    always_comb begin
        seen_nxt = (frame_done && !hs) ? '0 : seen;
        if (accept && code_ok) seen_nxt[samp_idx] = 1'b1;
    end

    // Digit store, snapshot handshake, error and overrun flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seen        <= '0;
            digit_reg   <= '0;
            out_valid   <= 1'b0;
            out_digits  <= '0;
            pattern_err <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            seen        <= seen_nxt;
            pattern_err <= accept && !code_ok;
            if (accept && code_ok) digit_reg[samp_idx] <= samp_code;
            if (hs) begin
                out_valid <= 1'b0;
            end else if (frame_done && !out_valid) begin
                out_valid  <= 1'b1;
                out_digits <= digit_reg;
            end
            if (frame_done && out_valid && !out_ready) overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_segment7_reader.sv
// Randomised + directed bench for segment7_reader with a run-length reference model.
// Frames are scoreboarded: model pushes snapshots, monitor pops on each handshake.
// Flags (out_valid, pattern_err, overrun) are compared every cycle.
module tb_segment7_reader;

    localparam int ND = 4;
    localparam int SC = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [6:0]      seg;
    logic [ND-1:0]   anode;
    logic            out_ready;
    logic            out_valid;
    logic [4*ND-1:0] out_digits;
    logic            pattern_err;
    logic            overrun;

    int checks = 0;
    int errors = 0;
    bit rdy_rand = 1'b0;

    logic [6:0] pats [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                              7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

    segment7_reader #(.NUM_DIGITS(ND), .STABLE_CNT(SC)) dut (
        .clk(clk), .rst(rst), .seg(seg), .anode(anode), .out_ready(out_ready),
        .out_valid(out_valid), .out_digits(out_digits),
        .pattern_err(pattern_err), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] ref_decode(input logic [6:0] p);
        for (int k = 0; k < 10; k++)
            if (p == pats[k]) return 4'(k);
`ifdef SEG7_READER_BLANK_EN
        if (p == 7'h7F) return 4'hA;
`endif
        return 4'hF;
    endfunction

    // ---------------- reference model ----------------
    logic [6:0]      m_sq;
    logic [ND-1:0]   m_aq;
    int              run_len, run_idx;
    logic [3:0]      run_code;
    logic [3:0]      m_digits [ND];
    logic [ND-1:0]   m_seen;
    logic            m_valid, m_perr, m_ovr;
    logic [4*ND-1:0] m_out;
    logic [4*ND-1:0] exp_q [$];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_sq = 7'h7F; m_aq = '1; run_len = 0; run_idx = 0; run_code = 4'h0;
            for (int i = 0; i < ND; i++) m_digits[i] = 4'h0;
            m_seen = '0; m_valid = 1'b0; m_perr = 1'b0; m_ovr = 1'b0; m_out = '0;
            exp_q.delete();
        end else begin
            int zeros, idx;
            logic [3:0] code;
            bit acc, hs, done, v_old;
            zeros = ND - $countones(m_aq);
            idx = 0;
            for (int i = 0; i < ND; i++) if (!m_aq[i]) idx = i;
            code = ref_decode(m_sq);
            acc = 1'b0;
            if (zeros == 1) begin
                if (run_len > 0 && idx == run_idx && code == run_code) begin
                    if (run_len <= SC) run_len++;
                end else begin
                    run_len = 1; run_idx = idx; run_code = code;
                end
                acc = (run_len == SC);
            end else begin
                run_len = 0;
            end
            v_old = m_valid;
            hs    = v_old && out_ready;
            done  = (m_seen == {ND{1'b1}});
            if (hs) m_valid = 1'b0;
            else if (done && !v_old) begin
                m_valid = 1'b1;
                for (int i = 0; i < ND; i++) m_out[4*i +: 4] = m_digits[i];
                exp_q.push_back(m_out);
            end
            if (done && v_old && !out_ready) m_ovr = 1'b1;
            if (done && !hs) m_seen = '0;
            m_perr = acc && (code == 4'hF);
            if (acc && code != 4'hF) begin
                m_digits[idx] = code;
                m_seen[idx] = 1'b1;
            end
            m_sq = seg;
            m_aq = anode;
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("pattern_err", 32'(pattern_err), 32'(m_perr));
        chk("overrun", 32'(overrun), 32'(m_ovr));
        if (out_valid && out_ready && !rst) begin
            if (exp_q.size() == 0) chk("frame_unexpected", 32'(out_digits), 32'hDEAD_BEEF);
            else chk("frame_digits", 32'(out_digits), 32'(exp_q.pop_front()));
        end
    end

    // ---------------- stimulus ----------------
    function automatic logic [ND-1:0] an_of(input int i);
        logic [ND-1:0] one;
        one = 1;
        return ~(one << i);
    endfunction

    task automatic drive(input logic [6:0] s, input logic [ND-1:0] an, input int n);
        repeat (n) begin
            @(posedge clk); #1;
            seg = s; anode = an;
            if (rdy_rand) out_ready = 1'($urandom % 2);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        @(negedge clk);
        chk({tag, "_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_digits"}, 32'(out_digits), 32'd0);
        chk({tag, "_perr"}, 32'(pattern_err), 32'd0);
        chk({tag, "_ovr"}, 32'(overrun), 32'd0);
    endtask

    task automatic full_frame(input int hold);
        for (int d = 0; d < ND; d++) drive(pats[$urandom_range(0, 9)], an_of(d), hold);
    endtask

    initial begin
        rst = 1'b1; seg = 7'h7F; anode = '1; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1; rst = 1'b0;

        // Directed frame 2,1,2,3 -> 16'h3212 held until ready.
        drive(pats[2], an_of(0), 4);
        drive(pats[1], an_of(1), 4);
        drive(pats[2], an_of(2), 4);
        drive(pats[3], an_of(3), 4);
        drive(7'h7F, '1, 1);
        begin
            int w;
            w = 0;
            while (!out_valid && w < 20) begin @(negedge clk); w++; end
            chk("frame_3212_wait", 32'(out_valid), 32'd1);
            chk("frame_3212", 32'(out_digits), 32'h3212);
        end
        drive(7'h7F, '1, 2);
        out_ready = 1'b1;
        drive(7'h7F, '1, 2);

        // Short hold (3 cycles) is not accepted; then a different pattern.
        drive(pats[3], an_of(0), 3);
        drive(pats[8], an_of(0), 2);
        drive(7'h7F, '1, 2);

        // Unrecognised pattern held long enough -> one error pulse.
        drive(7'b1110000, an_of(1), 4);
        drive(7'h7F, '1, 3);

        // Two frames with no ready -> overrun, first snapshot kept.
        out_ready = 1'b0;
        full_frame(5);
        drive(7'h7F, '1, 3);
        full_frame(5);
        drive(7'h7F, '1, 3);
        @(negedge clk);
        chk("overrun_set", 32'(overrun), 32'd1);
        drive(7'h7F, '1, 1);
        out_ready = 1'b1;
        drive(7'h7F, '1, 3);

        // Invalid anode masks interrupt tracking.
        drive(pats[5], an_of(2), 2);
        drive(pats[5], 4'b1100, 1);
        drive(pats[5], an_of(2), 3);
        drive(pats[5], 4'b1111, 1);
        drive(pats[5], an_of(2), 2);
        drive(7'h7F, '1, 2);

        // Reset after three accepted digits discards the partial frame.
        for (int d = 0; d < 3; d++) drive(pats[d + 4], an_of(d), 5);
        @(posedge clk); #1; rst = 1'b1;
        check_reset_outputs("midreset");
        @(posedge clk); #1; rst = 1'b0;
        drive(pats[9], an_of(3), 5);
        drive(7'h7F, '1, 4);
        full_frame(4);
        drive(7'h7F, '1, 4);

        // Random traffic with random ready.
        rdy_rand = 1'b1;
        for (int n = 0; n < 250; n++) begin
            logic [6:0] s;
            logic [ND-1:0] an;
            int r;
            r = $urandom_range(0, 9);
            if (r < 7)       s = pats[$urandom_range(0, 9)];
            else if (r == 7) s = 7'h7F;
            else             s = 7'($urandom);
            r = $urandom_range(0, 9);
            if (r < 8) an = an_of($urandom_range(0, ND - 1));
            else       an = ND'($urandom);
            drive(s, an, $urandom_range(1, 7));
        end

        // Drain any pending snapshot.
        rdy_rand = 1'b0;
        out_ready = 1'b1;
        drive(7'h7F, '1, 10);
        @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/segment7_reader.md
SEGMENT7_READER -- requirements
Module: segment7_reader

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4: number of multiplexed digits observed.
REQ-002 SHALL have parameter STABLE_CNT, default 4: consecutive identical samples required to accept a digit; legal range 1..15.
REQ-003 SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-005 SHALL have port seg, input, 7: active-low segment pattern; bit6=a … bit0=g.
REQ-006 SHALL have port anode, input, NUM_DIGITS: active-low digit select.
REQ-007 SHALL have port out_ready, input, 1: consumer accepts the frame.
REQ-008 SHALL have port out_valid, output, 1: frame snapshot available.
REQ-009 SHALL have port out_digits, output, 4*NUM_DIGITS: BCD snapshot; digit i at bits [4i+3:4i].
REQ-010 SHALL have port pattern_err, output, 1: one-cycle pulse on acceptance of an unrecognised pattern.
REQ-011 SHALL have port overrun, output, 1: sticky; a frame completed while out_valid was pending.

Function
REQ-012 SHALL register seg and anode once before use, adding one cycle of latency.
REQ-013 SHALL treat a sample as valid only when exactly one anode bit is 0; all other samples return the FSM to S_IDLE and clear the counter.
REQ-014 SHALL map patterns 0000001,1001111,0010010,0000110,1001100,0100100,0100000,0001111,0000000,0000100 to codes 0..9; any other pattern SHALL map to 4'hF.
REQ-015 SHALL use FSM states S_IDLE (no valid sample), S_TRACK (counting identical samples) and S_HOLD (digit accepted, waiting for a change).
REQ-016 S_IDLE→S_TRACK on a valid sample, with counter=1 and the candidate (index, code) stored.
REQ-017 In S_TRACK, an identical sample SHALL increment the counter; a different valid sample SHALL restart the counter at 1 with the new candidate.
REQ-018 When the counter reaches STABLE_CNT, SHALL accept the candidate: store the code in digit_reg[index], set seen[index], and move to S_HOLD.
REQ-019 In S_HOLD, a different valid sample SHALL go to S_TRACK with counter=1; an identical sample SHALL stay.
REQ-020 An accepted code 4'hF SHALL pulse pattern_err, SHALL NOT update digit_reg, and SHALL NOT set seen.
REQ-021 When all seen bits are set and out_valid=0, SHALL copy digit_reg to out_digits, assert out_valid, and clear seen in the same cycle.
REQ-022 out_valid and out_digits SHALL hold until a cycle with out_valid&&out_ready; out_valid deasserts on the next edge.
REQ-023 A frame completing while out_valid=1 SHALL set overrun, keep the old snapshot, and clear seen.
REQ-024 Acceptance and handshake in the same cycle: the handshake completes first; the new frame asserts out_valid on the following edge.
REQ-025 Latency: a digit is present for STABLE_CNT consecutive cycles and becomes accepted on edge STABLE_CNT+1 after first presentation.

Reset
REQ-026 rst SHALL asynchronously set: FSM=S_IDLE, counter=0, seen=0, digit_reg=0, out_digits=0, out_valid=0, pattern_err=0, overrun=0, input registers=all ones.
REQ-027 rst asserted mid-track or mid-handshake SHALL discard the partial frame; no out_valid before a new complete frame.

Configuration
REQ-028 With SEG7_READER_BLANK_EN defined, pattern 1111111 SHALL map to code 4'hA (blank), be stored, and set seen without pattern_err.
REQ-029 Without SEG7_READER_BLANK_EN, 1111111 SHALL be treated per REQ-020.

Structure
REQ-030 Package segment7_pkg SHALL hold the state enum, the ten pattern constants, and CODE_INVALID=4'hF and CODE_BLANK=4'hA.
REQ-031 Sub-module segment7_encode (combinational pattern→code) SHALL be instantiated once.

Verification
REQ-032 seg=0010010, anode=1110 held 4 cycles, then digits 1,2,3 each held 4 cycles on their anodes -> out_valid=1, out_digits=16'h3212.
REQ-033 seg=0000110 held 3 cycles, then 0000000 (STABLE_CNT=4) -> digit 3 not accepted; seen[0] stays 0.
REQ-034 seg=1110000 held 4 cycles -> pattern_err pulses 1 cycle; digit_reg unchanged.
REQ-035 Two full frames with out_ready=0 -> overrun=1; out_digits keep the first frame; out_ready=1 -> out_valid falls next edge.
REQ-036 anode=1100 or 1111 during tracking -> FSM=S_IDLE, counter=0, no acceptance.
REQ-037 rst pulse after 3 accepted digits -> all outputs 0; a fresh full frame is required for out_valid.
